adc_qsys_nios2_gen2_jtag_debug_host: RTL and testbench

Host-side initiator for the Nios II virtual-JTAG debug slave. It accepts one command at a time: a 2-bit IR value and a 38-bit DR value. For each command it drives the complete virtual-JTAG sequence (UIR, CDR, SDR, UDR, RTI) on the `vji_*` signals, with TCK divided down from the system clock. It captures the TDO bits shifted back and returns them as a response. It sits in place of `sld_virtual_jtag_basic` for on-chip debug self-test and simulation of the debug slave.

---
 rtl/adc_qsys_nios2_gen2_jtag_debug_host.sv | 135 +++++++++++++
 tb/tb_adc_qsys_nios2_gen2_jtag_debug_host.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_qsys_nios2_gen2_jtag_debug_host.sv
// rtl/adc_qsys_nios2_gen2_jtag_debug_host.sv - host-side virtual-JTAG initiator for the Nios II debug slave
module adc_qsys_nios2_gen2_jtag_debug_host #(
   parameter int IR_WIDTH = 2,
   parameter int DR_WIDTH = 38,
   parameter int TCK_DIV  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic [IR_WIDTH-1:0] rsp_ir_out,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   input  logic [IR_WIDTH-1:0] vji_ir_out,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti
);

   localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
   localparam int BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

   // S_DONE is a one-cycle settle between the last TCK period and the response
   typedef enum logic [2:0] {
      S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_DONE, S_RESP
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [DIV_W-1:0]     div_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DR_WIDTH-1:0]  dr_q;
   logic                 active;
   logic                 half_end;
   logic                 period_end;
   logic                 last_bit;
   logic                 accept;

   assign active     = (state_q == S_UIR) || (state_q == S_CDR) || (state_q == S_SDR) ||
                       (state_q == S_UDR) || (state_q == S_RTI);
   assign half_end   = (div_cnt == DIV_LAST);
   assign period_end = active && half_end && vji_tck;
   assign last_bit   = (bit_cnt == BIT_LAST);
   assign accept     = (state_q == S_IDLE) && cmd_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (cmd_valid) state_d = S_UIR;
         S_UIR:  if (period_end) state_d = S_CDR;
         S_CDR:  if (period_end) state_d = S_SDR;
         S_SDR:  if (period_end && last_bit) state_d = S_UDR;
         S_UDR:  if (period_end) state_d = S_RTI;
         S_RTI:  if (period_end) state_d = S_DONE;
         S_DONE: state_d = S_RESP;
         S_RESP: if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      vji_uir   = 1'b0;
      vji_cdr   = 1'b0;
      vji_sdr   = 1'b0;
      vji_udr   = 1'b0;
      vji_rti   = 1'b0;
      vji_tdi   = 1'b0;
      case (state_q)
         S_IDLE: cmd_ready = 1'b1;
         S_UIR:  vji_uir   = 1'b1;
         S_CDR:  vji_cdr   = 1'b1;
         S_SDR: begin
            vji_sdr = 1'b1;
            vji_tdi = dr_q[bit_cnt];
         end
         S_UDR:  vji_udr   = 1'b1;
         S_RTI:  vji_rti   = 1'b1;
         S_RESP: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // TDO and IR status are taken on the edge that raises TCK; bit_cnt moves only at period ends
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt    <= '0;
         bit_cnt    <= '0;
         vji_tck    <= 1'b0;
         dr_q       <= '0;
         vji_ir_in  <= '0;
         rsp_dr     <= '0;
         rsp_ir_out <= '0;
      end else if (active) begin
         if (half_end) begin
            div_cnt <= '0;
            vji_tck <= ~vji_tck;
            if (!vji_tck && state_q == S_CDR) rsp_ir_out <= vji_ir_out;
            if (!vji_tck && state_q == S_SDR) rsp_dr[bit_cnt] <= vji_tdo;
            if (vji_tck) bit_cnt <= (state_q == S_SDR && !last_bit) ? bit_cnt + 1'b1 : '0;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end else begin
         div_cnt <= '0;
         bit_cnt <= '0;
         vji_tck <= 1'b0;
         if (accept) begin
            vji_ir_in <= cmd_ir;
            dr_q      <= cmd_dr;
         end
      end
   end

endmodule

// File: tb/tb_adc_qsys_nios2_gen2_jtag_debug_host.sv
// tb/tb_adc_qsys_nios2_gen2_jtag_debug_host.sv - self-checking bench for the virtual-JTAG debug host
module tb_adc_qsys_nios2_gen2_jtag_debug_host;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // default instance with a shift-register target
   logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
   logic [1:0]  cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
   logic [37:0] cmd_dr, rsp_dr;
   logic        vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

   adc_qsys_nios2_gen2_jtag_debug_host u_dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out), .vji_tck(vji_tck), .vji_tdi(vji_tdi),
      .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out), .vji_uir(vji_uir),
      .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti));

   // TCK_DIV=1 instance, TDO looped straight back from TDI
   logic        f_valid, f_ready, f_cmd_ready, f_rsp_valid;
   logic [1:0]  f_rsp_ir, f_ir_in;
   logic [37:0] f_dr, f_rsp_dr;
   logic        f_tck, f_tdi, f_uir, f_cdr, f_sdr, f_udr, f_rti;

   adc_qsys_nios2_gen2_jtag_debug_host #(.TCK_DIV(1)) u_fast (
      .clk(clk), .reset(reset), .cmd_valid(f_valid), .cmd_ready(f_cmd_ready),
      .cmd_ir(2'b01), .cmd_dr(f_dr), .rsp_valid(f_rsp_valid), .rsp_ready(f_ready),
      .rsp_dr(f_rsp_dr), .rsp_ir_out(f_rsp_ir), .vji_tck(f_tck), .vji_tdi(f_tdi),
      .vji_tdo(f_tdi), .vji_ir_in(f_ir_in), .vji_ir_out(2'b10), .vji_uir(f_uir),
      .vji_cdr(f_cdr), .vji_sdr(f_sdr), .vji_udr(f_udr), .vji_rti(f_rti));

   // TCK_DIV=3 instance
   logic        s_valid, s_ready, s_cmd_ready, s_rsp_valid;
   logic [1:0]  s_rsp_ir, s_ir_in;
   logic [37:0] s_dr, s_rsp_dr;
   logic        s_tck, s_tdi, s_uir, s_cdr, s_sdr, s_udr, s_rti;

   adc_qsys_nios2_gen2_jtag_debug_host #(.TCK_DIV(3)) u_slow (
      .clk(clk), .reset(reset), .cmd_valid(s_valid), .cmd_ready(s_cmd_ready),
      .cmd_ir(2'b10), .cmd_dr(s_dr), .rsp_valid(s_rsp_valid), .rsp_ready(s_ready),
      .rsp_dr(s_rsp_dr), .rsp_ir_out(s_rsp_ir), .vji_tck(s_tck), .vji_tdi(s_tdi),
      .vji_tdo(s_tdi), .vji_ir_in(s_ir_in), .vji_ir_out(2'b01), .vji_uir(s_uir),
      .vji_cdr(s_cdr), .vji_sdr(s_sdr), .vji_udr(s_udr), .vji_rti(s_rti));

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // target model: captures tgt_cap in CDR, shifts right with TDI on each TCK rise in SDR
   logic [37:0] tgt_sr, tgt_cap;
   assign vji_tdo    = tgt_sr[0];
   assign vji_ir_out = ~vji_ir_in;
   always @(posedge vji_tck) begin
      if (vji_cdr)      tgt_sr <= tgt_cap;
      else if (vji_sdr) tgt_sr <= {vji_tdi, tgt_sr[37:1]};
   end

   int n_uir, n_cdr, n_sdr, n_udr, n_rti, n_rsp;
   always @(posedge vji_tck) begin
      if (vji_uir) n_uir++;
      if (vji_cdr) n_cdr++;
      if (vji_sdr) n_sdr++;
      if (vji_udr) n_udr++;
      if (vji_rti) n_rti++;
   end
   always @(posedge clk) if (rsp_valid && rsp_ready) n_rsp++;

   int fn_uir, fn_cdr, fn_sdr, fn_udr, fn_rti;
   always @(posedge f_tck) begin
      if (f_uir) fn_uir++;
      if (f_cdr) fn_cdr++;
      if (f_sdr) fn_sdr++;
      if (f_udr) fn_udr++;
      if (f_rti) fn_rti++;
   end

   // divider-instance phase and strobe-alignment monitor
   int s_rises = 0, div_bad = 0, edge_bad = 0, run_len = 0;
   logic [4:0] s_prev_str = '0;
   logic       s_prev_tck = 1'b0;
   always @(posedge s_tck) s_rises++;
   always @(posedge clk) begin
      logic [4:0] str;
      #1;
      str = {s_uir, s_cdr, s_sdr, s_udr, s_rti};
      if (str != s_prev_str && !(s_tck == 1'b0 && (s_prev_tck == 1'b1 || s_prev_str == 5'd0)))
         edge_bad++;
      if (s_prev_str == 5'd0 && str != 5'd0) begin
         run_len = 1;
      end else if (s_tck != s_prev_tck) begin
         if (run_len != 3) div_bad++;
         run_len = 1;
      end else begin
         run_len++;
      end
      s_prev_str = str;
      s_prev_tck = s_tck;
   end

   typedef struct {
      logic [1:0]  ir;
      logic [37:0] dr;
      logic [37:0] cap;
      int          hold;
      bit          poke;
      logic [37:0] exp_rsp;
      logic [1:0]  exp_ir;
      logic [37:0] exp_sr;
      int          exp_lat;
   } vec_t;

   // reference: response = target capture, IR status = model's ~ir, target ends holding the command DR
   function automatic vec_t mk(input logic [1:0] ir, input logic [37:0] dr, input logic [37:0] cap,
                               input int hold, input bit poke);
      vec_t v;
      v.ir = ir; v.dr = dr; v.cap = cap; v.hold = hold; v.poke = poke;
      v.exp_rsp = cap;
      v.exp_ir  = ~ir;
      v.exp_sr  = dr;
      v.exp_lat = (38 + 4) * 2 * 2 + 1;
      return v;
   endfunction

   task automatic run_cmd(input vec_t v, output logic [37:0] got_dr, output logic [1:0] got_ir,
                          output int lat);
      int c;
      int bad;
      tgt_cap = v.cap;
      n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
      c = 0;
      while (!cmd_ready && c < 500) begin @(posedge clk); #1; c++; end
      check("idle_before_cmd", cmd_ready, 1'b1);
      cmd_ir = v.ir; cmd_dr = v.dr; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("uir_first_cycle", {vji_uir, vji_tck, cmd_ready}, 3'b100);
      lat = 0;
      while (!rsp_valid && lat < 2000) begin
         if (v.poke && lat == 20) begin cmd_valid = 1'b1; cmd_ir = 2'b11; end
         if (v.poke && lat == 21) cmd_valid = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      got_dr = rsp_dr;
      got_ir = rsp_ir_out;
      bad = 0;
      for (int i = 0; i < v.hold; i++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_dr !== got_dr || cmd_ready !== 1'b0 || vji_tck !== 1'b0) bad++;
      end
      if (v.hold > 0) check("backpressure_stable", bad, 0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("ready_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
   endtask

   vec_t vecs[10];

   initial begin
      logic [37:0] gdr;
      logic [1:0]  gir;
      int          lat;
      int          cnt;

      vecs[0] = mk(2'b01, 38'h15_1234_5678, 38'h2A_DEAD_BEEF, 0, 1'b0);
      vecs[1] = mk(2'b00, 38'h3F_FFFF_FFFF, 38'h00_0000_0000, 50, 1'b0);
      vecs[2] = mk(2'b10, 38'h00_0000_0001, 38'h20_0000_0000, 0, 1'b1);
      vecs[3] = mk(2'b11, 38'h20_0000_0000, 38'h3F_FFFF_FFFF, 0, 1'b0);
      for (int i = 4; i < 10; i++)
         vecs[i] = mk(2'($urandom_range(0, 3)), 38'({$urandom(), $urandom()}),
                      38'({$urandom(), $urandom()}), 0, 1'b0);

      reset = 1'b1;
      cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_ir = '0; cmd_dr = '0;
      f_valid = 1'b0; f_ready = 1'b0; f_dr = '0;
      s_valid = 1'b0; s_ready = 1'b0; s_dr = '0;
      tgt_sr = '0; tgt_cap = '0; n_rsp = 0;
      fn_uir = 0; fn_cdr = 0; fn_sdr = 0; fn_udr = 0; fn_rti = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready_valid", {cmd_ready, rsp_valid}, 2'b10);
      check("reset_rsp", {rsp_dr, rsp_ir_out}, 40'd0);
      check("reset_vji", {vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 9'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // reset mid-SDR: outputs drop without a clock edge and no response follows
      tgt_cap = 38'h11_2233_4455;
      cmd_ir = 2'b01; cmd_dr = 38'h0A_5A5A_5A5A; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("in_sdr_before_reset", vji_sdr, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("async_reset", {vji_sdr, vji_tck, cmd_ready, rsp_valid, vji_ir_in}, 6'b001000);
      @(posedge clk); #1;
      reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 250; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) cnt++;
      end
      check("no_rsp_after_reset", cnt, 0);

      foreach (vecs[k]) begin
         run_cmd(vecs[k], gdr, gir, lat);
         check($sformatf("latency[%0d]", k), lat, vecs[k].exp_lat);
         check($sformatf("rsp_dr[%0d]", k), gdr, vecs[k].exp_rsp);
         check($sformatf("rsp_ir_out[%0d]", k), gir, vecs[k].exp_ir);
         check($sformatf("target_sr[%0d]", k), tgt_sr, vecs[k].exp_sr);
         check($sformatf("ir_in_held[%0d]", k), vji_ir_in, vecs[k].ir);
         check($sformatf("tck_rises[%0d]", k),
               {8'(n_uir), 8'(n_cdr), 8'(n_sdr), 8'(n_udr), 8'(n_rti)}, {8'd1, 8'd1, 8'd38, 8'd1, 8'd1});
      end
      repeat (200) @(posedge clk);
      #1;
      check("response_count", n_rsp, 10);

      // TCK_DIV=1 latency and strobe rise counts
      f_dr = 38'({$urandom(), $urandom()});
      f_valid = 1'b1;
      @(posedge clk); #1;
      f_valid = 1'b0;
      lat = 0;
      while (!f_rsp_valid && lat < 1000) begin @(posedge clk); #1; lat++; end
      check("fast_latency", lat, 85);
      check("fast_rsp_dr", f_rsp_dr, f_dr);
      check("fast_rsp_ir", f_rsp_ir, 2'b10);
      check("fast_tck_rises", {8'(fn_uir), 8'(fn_cdr), 8'(fn_sdr), 8'(fn_udr), 8'(fn_rti)},
            {8'd1, 8'd1, 8'd38, 8'd1, 8'd1});
      f_ready = 1'b1;
      @(posedge clk); #1;
      f_ready = 1'b0;
      check("fast_ready_after", f_cmd_ready, 1'b1);

      // TCK_DIV=3 phase lengths and strobe alignment
      s_dr = 38'({$urandom(), $urandom()});
      s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      lat = 0;
      while (!s_rsp_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
      check("slow_latency", lat, 42 * 6 + 1);
      check("slow_rsp_dr", s_rsp_dr, s_dr);
      check("slow_tck_rises", s_rises, 42);
      check("slow_phase_len", div_bad, 0);
      check("slow_strobe_align", edge_bad, 0);
      s_ready = 1'b1;
      @(posedge clk); #1;
      s_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
